// File: rtl/fantastic_fft8_frame_ctrl.sv
// Frame sequencer for the 8-point Q8.8 FFT core: serial samples in, one launch per frame, bins out.
// Optional macro FFT8_FRAME_CTRL_FRAMECNT_EN adds a 16-bit completed-frame counter port.
module fantastic_fft8_frame_ctrl #(
  parameter int DATA_W      = 16,
  parameter int FFT_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic [8*DATA_W-1:0]   fft_x,
  output logic                  fft_valid,
  input  logic [8*DATA_W-1:0]   fft_y_re,
  input  logic [8*DATA_W-1:0]   fft_y_im,
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
  output logic [15:0]           frame_cnt,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_re,
  output logic [DATA_W-1:0]     out_im,
  output logic [2:0]            out_idx,
  output logic                  out_last,
  output logic                  busy
);

  localparam int LAT_W = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_wr_idx;
  logic [2:0]          r_rd_idx;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_buf    [8];
  logic [DATA_W-1:0]   r_res_re [8];
  logic [DATA_W-1:0]   r_res_im [8];
  logic [8*DATA_W-1:0] r_fft_x;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
  logic [15:0]         r_frame_cnt;
`endif

  logic w_drain;
  assign w_drain = (r_state == S_DRAIN);

  // in_ready drops combinationally with rst_n so nothing is accepted in the reset cycle
  assign in_ready  = rst_n && (r_state == S_FILL);
  assign fft_valid = (r_state == S_LAUNCH);
  assign fft_x     = r_fft_x;
  assign busy      = (r_state != S_FILL);
  assign out_valid = w_drain;
  assign out_idx   = w_drain ? r_rd_idx : 3'd0;
  assign out_last  = w_drain && (r_rd_idx == 3'd7);
  assign out_re    = w_drain ? r_res_re[r_rd_idx] : '0;
  assign out_im    = w_drain ? r_res_im[r_rd_idx] : '0;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
  assign frame_cnt = r_frame_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_wr_idx  <= 3'd0;
      r_rd_idx  <= 3'd0;
      r_lat_cnt <= '0;
      r_fft_x   <= '0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i]    <= '0;
        r_res_re[i] <= '0;
        r_res_im[i] <= '0;
      end
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
      r_frame_cnt <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_buf[r_wr_idx] <= in_data;
            r_wr_idx        <= r_wr_idx + 3'd1;
            // Last sample bypasses the buffer so the core sees the full frame during LAUNCH
            if (r_wr_idx == 3'd7) begin
              for (int i = 0; i < 7; i++) r_fft_x[i*DATA_W +: DATA_W] <= r_buf[i];
              r_fft_x[7*DATA_W +: DATA_W] <= in_data;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_lat_cnt <= LAT_W'(FFT_LATENCY - 1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            for (int i = 0; i < 8; i++) begin
              r_res_re[i] <= fft_y_re[i*DATA_W +: DATA_W];
              r_res_im[i] <= fft_y_im[i*DATA_W +: DATA_W];
            end
            r_rd_idx <= 3'd0;
            r_state  <= S_DRAIN;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_rd_idx <= r_rd_idx + 3'd1;
            if (r_rd_idx == 3'd7) begin
              r_state <= S_FILL;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
              r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fantastic_fft8_frame_ctrl.sv
// Directed bench for fantastic_fft8_frame_ctrl with a behavioural 8-point DFT core of latency 3.
module tb_fantastic_fft8_frame_ctrl;

  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam real PI = 3.14159265358979323846;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [8*DW-1:0] fft_x;
  logic            fft_valid;
  logic [8*DW-1:0] fft_y_re;
  logic [8*DW-1:0] fft_y_im;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_re;
  logic [DW-1:0]   out_im;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            busy;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
  logic [15:0]     frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int age = 0;
  logic [DW-1:0] pend_re [8];
  logic [DW-1:0] pend_im [8];

  fantastic_fft8_frame_ctrl #(.DATA_W(DW), .FFT_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fft_x(fft_x), .fft_valid(fft_valid), .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
    .frame_cnt(frame_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: real DFT rounded to Q8.8, outputs valid only in the cycle before the capture edge
  function automatic logic [DW-1:0] dft_bin(input logic [8*DW-1:0] x, input int k, input bit imag);
    real acc, ang, xs;
    int xi, r;
    acc = 0.0;
    for (int n = 0; n < 8; n++) begin
      xi  = int'($signed(x[n*DW +: DW]));
      xs  = $itor(xi);
      ang = 2.0 * PI * $itor(k * n) / 8.0;
      acc = imag ? acc - xs * $sin(ang) : acc + xs * $cos(ang);
    end
    r = $rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5);
    return r[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (fft_valid === 1'b1) begin
      for (int k = 0; k < 8; k++) begin
        pend_re[k] <= dft_bin(fft_x, k, 1'b0);
        pend_im[k] <= dft_bin(fft_x, k, 1'b1);
      end
      age <= 1;
      fv_count <= fv_count + 1;
    end else if (age != 0 && age <= LAT) begin
      age <= age + 1;
    end
  end

  always_comb begin
    fft_y_re = {8{16'hDEAD}};
    fft_y_im = {8{16'hBEEF}};
    if (age == LAT) begin
      for (int k = 0; k < 8; k++) begin
        fft_y_re[k*DW +: DW] = pend_re[k];
        fft_y_im[k*DW +: DW] = pend_im[k];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame; returns in the cycle after the 8th acceptance with in_valid low
  task automatic feed(input logic [8*DW-1:0] frame, input bit gaps);
    int n;
    bit gap;
    n = 0;
    gap = 1'b0;
    while (n < 8) begin
      if (gaps && gap) begin
        in_valid = 1'b0;
        in_data  = 16'hBAD0;
      end else begin
        in_valid = 1'b1;
        in_data  = frame[n*DW +: DW];
        n++;
      end
      gap = ~gap;
      tick();
      if (n < 8) begin
        checks++;
        if (fft_valid !== 1'b0) begin errors++; $display("FAIL feed_early_fft_valid: got %b want 0 after %0d samples", fft_valid, n); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_fill;
    int k;
    k = 0;
    while (!(in_ready === 1'b1 && busy === 1'b0) && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 40) begin errors++; $display("FAIL wait_fill_timeout: got busy=%b in_ready=%b want idle", busy, in_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (fft_valid !== 1'b0) begin errors++; $display("FAIL rst_fft_valid: got %b want 0", fft_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (fft_x !== '0) begin errors++; $display("FAIL rst_fft_x: got %h want 0", fft_x); end
    checks++; if ({out_re, out_im, out_idx, out_last} !== '0) begin errors++; $display("FAIL rst_out: got %h %h %0d %b want 0", out_re, out_im, out_idx, out_last); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ramp(input logic [8*DW-1:0] ramp);
    out_ready = 1'b1;
    feed(ramp, 1'b0);
    checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL ramp_fft_valid_T1: got %b want 1", fft_valid); end
    checks++; if (fft_x[15:0] !== 16'h0100) begin errors++; $display("FAIL ramp_x0: got %h want 0100", fft_x[15:0]); end
    checks++; if (fft_x[127:112] !== 16'h0800) begin errors++; $display("FAIL ramp_x7: got %h want 0800", fft_x[127:112]); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ramp_launch_flags: got in_ready=%b busy=%b want 0 1", in_ready, busy); end
    tick();
    checks++; if (fft_valid !== 1'b0) begin errors++; $display("FAIL ramp_fft_valid_pulse: got %b want 0", fft_valid); end
    for (int c = 2; c <= 4; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_early_out_valid: got %b want 0 at T+%0d", out_valid, c); end
      if (c < 4) tick();
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin errors++; $display("FAIL ramp_bin_seq: got valid=%b idx=%0d want 1 %0d", out_valid, out_idx, k); end
      checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL ramp_last: got %b want %b at bin %0d", out_last, (k == 7), k); end
      if (k == 0) begin
        checks++; if (out_re !== 16'h2400 || out_im !== 16'h0000) begin errors++; $display("FAIL ramp_bin0: got %h %h want 2400 0000", out_re, out_im); end
      end
      if (k == 2) begin
        checks++; if (out_re !== 16'hFC00 || out_im !== 16'h0400) begin errors++; $display("FAIL ramp_bin2: got %h %h want fc00 0400", out_re, out_im); end
      end
      if (k == 4) begin
        checks++; if (out_re !== 16'hFC00 || out_im !== 16'h0000) begin errors++; $display("FAIL ramp_bin4: got %h %h want fc00 0000", out_re, out_im); end
      end
      tick();
    end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ramp_back_to_fill: got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
  endtask

  task automatic test_backpressure(input logic [8*DW-1:0] ramp);
    int k;
    out_ready = 1'b1;
    feed(ramp, 1'b0);
    k = 0;
    while (!(out_valid === 1'b1 && out_idx === 3'd3) && k < 30) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    checks++; if (k >= 30) begin errors++; $display("FAIL bp_reach_bin3: got idx=%0d valid=%b want bin 3", out_idx, out_valid); end
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_re !== 16'hFC00 || out_im !== 16'h01A8) begin
        errors++; $display("FAIL bp_hold: got valid=%b idx=%0d re=%h im=%h want 1 3 fc00 01a8", out_valid, out_idx, out_re, out_im);
      end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'(3 + j)) begin errors++; $display("FAIL bp_release: got valid=%b idx=%0d want 1 %0d", out_valid, out_idx, 3 + j); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_done: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_gaps;
    logic [8*DW-1:0] g;
    int fv0;
    for (int i = 0; i < 8; i++) g[i*DW +: DW] = 16'(16'h0F00 - i * 16'h0111);
    fv0 = fv_count;
    out_ready = 1'b1;
    feed(g, 1'b1);
    checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL gaps_fft_valid: got %b want 1", fft_valid); end
    checks++; if (fft_x !== g) begin errors++; $display("FAIL gaps_order: got %h want %h", fft_x, g); end
    wait_fill();
    checks++; if (fv_count !== fv0 + 1) begin errors++; $display("FAIL gaps_launch_count: got %0d want %0d", fv_count - fv0, 1); end
  endtask

  task automatic test_reset_midfill;
    int fv0;
    int k;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0300;
      tick();
    end
    rst_n    = 1'b0;
    in_data  = 16'h0500;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_low: got %b want 0", in_ready); end
    fv0 = fv_count;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    feed({8{16'h0100}}, 1'b0);
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    checks++;
    if (out_idx !== 3'd0 || out_re !== 16'h0800 || out_im !== 16'h0000) begin
      errors++; $display("FAIL midrst_bin0: got idx=%0d re=%h im=%h want 0 0800 0000", out_idx, out_re, out_im);
    end
    wait_fill();
    checks++; if (fv_count !== fv0 + 1) begin errors++; $display("FAIL midrst_launch_count: got %0d want 1", fv_count - fv0); end
  endtask

  task automatic test_hold_input(input logic [8*DW-1:0] ramp);
    int k;
    out_ready = 1'b1;
    feed(ramp, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h7F00;
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k !== 12) begin errors++; $display("FAIL hold_busy_cycles: got %0d want 12", k); end
    tick();
    in_data = 16'h0000;
    for (int i = 1; i < 8; i++) tick();
    in_valid = 1'b0;
    checks++; if (fft_valid !== 1'b1) begin errors++; $display("FAIL hold_launch: got %b want 1", fft_valid); end
    checks++; if (fft_x !== 128'h7F00) begin errors++; $display("FAIL hold_frame: got %h want %h", fft_x, 128'h7F00); end
    wait_fill();
  endtask

`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
  task automatic test_framecnt(input logic [8*DW-1:0] ramp);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL fc_reset: got %0d want 0", frame_cnt); end
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      feed(ramp, 1'b0);
      wait_fill();
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL fc_three: got %0d want 3", frame_cnt); end
  endtask
`endif

  initial begin
    logic [8*DW-1:0] ramp;
    for (int i = 0; i < 8; i++) ramp[i*DW +: DW] = 16'((i + 1) * 256);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_ramp(ramp);
    test_backpressure(ramp);
    test_gaps();
    test_reset_midfill();
    test_hold_input(ramp);
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
    test_framecnt(ramp);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
